// File: rtl/sent_pkg.sv
// Shared SENT definitions: fast-channel format codes, RX state encoding, word width.
package sent_pkg;

  localparam int unsigned SENT_WORD_W = 12;

  localparam logic [2:0] SENT_FMT_OFF   = 3'b000;
  localparam logic [2:0] SENT_FMT_2X12  = 3'b001;
  localparam logic [2:0] SENT_FMT_14_10 = 3'b110;
  localparam logic [2:0] SENT_FMT_16_8  = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StWrite
  } rx_state_e;

endpackage

// File: rtl/sent_rx_unpack.sv
// Combinational unpacking of a decoded fast-channel frame into one or two 12-bit words.
module sent_rx_unpack
  import sent_pkg::*;
(
  input  logic [2:0]             config_bit_i,
  input  logic [15:0]            data_f1_i,
  input  logic [11:0]            data_f2_i,
  output logic [SENT_WORD_W-1:0] w1_o,
  output logic [SENT_WORD_W-1:0] w2_o,
  output logic                   two_words_o
);

  always_comb begin
    w1_o        = data_f1_i[11:0];
    w2_o        = '0;
    two_words_o = 1'b0;
    unique case (config_bit_i)
      SENT_FMT_2X12: begin
        w2_o        = data_f2_i;
        two_words_o = 1'b1;
      end
      SENT_FMT_14_10: begin
        w1_o        = data_f1_i[13:2];
        w2_o        = {data_f1_i[1:0], data_f2_i[9:0]};
        two_words_o = 1'b1;
      end
      SENT_FMT_16_8: begin
        w1_o        = data_f1_i[15:4];
        w2_o        = {data_f1_i[3:0], data_f2_i[7:0]};
        two_words_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sent_rx_data_reg.sv
// SENT RX data register: unpacks decoded frames and writes paced words into the RX FIFO.
// Optional SENT_RX_DROP_CNT_EN enables the saturating dropped-frame counter.
module sent_rx_data_reg
  import sent_pkg::*;
#(
  parameter int unsigned WR_GAP = 6
) (
  input  logic                   clk_rx,
  input  logic                   reset_n_rx,
  input  logic [2:0]             config_bit_i,
  input  logic [15:0]            data_f1_i,
  input  logic [11:0]            data_f2_i,
  input  logic                   done_data_i,
  input  logic                   fifo_rx_full_i,
  output logic [SENT_WORD_W-1:0] data_fast_o,
  output logic                   write_enable_rx_o,
  output logic                   busy_o,
  output logic                   frame_drop_o,
  output logic [7:0]             drop_count_o
);

  localparam logic [4:0] GapLast = 5'(WR_GAP - 1);

  rx_state_e              state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [SENT_WORD_W-1:0] cur_q, cur_d;
  logic [SENT_WORD_W-1:0] nxt_q, nxt_d;
  logic                   two_q, two_d;
  logic [SENT_WORD_W-1:0] data_q, data_d;
  logic                   drop_q, drop_d;

  logic [SENT_WORD_W-1:0] w1, w2;
  logic                   two_words;

  sent_rx_unpack u_unpack (
    .config_bit_i (config_bit_i),
    .data_f1_i    (data_f1_i),
    .data_f2_i    (data_f2_i),
    .w1_o         (w1),
    .w2_o         (w2),
    .two_words_o  (two_words)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    two_d   = two_q;
    data_d  = data_q;
    drop_d  = done_data_i && (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (done_data_i && (config_bit_i != SENT_FMT_OFF)) begin
          cur_d   = w1;
          nxt_d   = w2;
          two_d   = two_words;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // Counter parks at the last gap value while the FIFO is full.
        if (cnt_q == GapLast) begin
          if (!fifo_rx_full_i) begin
            data_d  = cur_q;
            state_d = StWrite;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StWrite: begin
        if (two_q) begin
          cur_d   = nxt_q;
          two_d   = 1'b0;
          cnt_d   = '0;
          state_d = StWait;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cur_q   <= '0;
      nxt_q   <= '0;
      two_q   <= 1'b0;
      data_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      two_q   <= two_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

`ifdef SENT_RX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count_o = drop_cnt_q;
`else
  assign drop_count_o = '0;
`endif

  assign data_fast_o       = data_q;
  assign write_enable_rx_o = (state_q == StWrite);
  assign busy_o            = (state_q != StIdle);
  assign frame_drop_o      = drop_q;

endmodule
